// File: rtl/env_pkg.sv
// Shared types and helpers for the ramping envelope generator.
package env_pkg;

   typedef enum logic [1:0] {IDLE, CALC, RAMP, SUSTAIN} env_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   function automatic int unsigned acc_w(input int unsigned level_w, input int unsigned frac_w);
      return level_w + frac_w;
   endfunction

endpackage

// File: rtl/env_div.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
module env_div #(
   parameter int unsigned NUM_W = 16,
   parameter int unsigned DEN_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             done,
   output logic [NUM_W-1:0] quo
);
   localparam int unsigned CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] quo_q;
   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;
   logic             done_q;
   logic [DEN_W:0]   rem_sh;
   logic [DEN_W:0]   trial;

   // rem_sh < 2*den, so the top bit of the trial difference is a valid borrow
   always_comb begin
      rem_sh = {rem_q, quo_q[NUM_W-1]};
      trial  = rem_sh - {1'b0, den_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            run_q <= 1'b0;
         end else if (start) begin
            quo_q <= num;
            rem_q <= '0;
            den_q <= den;
            cnt_q <= CNT_W'(NUM_W);
            run_q <= 1'b1;
         end else if (run_q) begin
            quo_q <= {quo_q[NUM_W-2:0], ~trial[DEN_W]};
            rem_q <= trial[DEN_W] ? rem_sh[DEN_W-1:0] : trial[DEN_W-1:0];
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign quo  = quo_q;

endmodule

// File: rtl/env_ramp.sv
// Multi-stage linear-ramp envelope generator with sustain, loop and
// click-free retrigger from the current level.
module env_ramp
   import env_pkg::*;
#(
   parameter int unsigned STAGES  = 4,
   parameter int unsigned LEVEL_W = 8,
   parameter int unsigned TIME_W  = 8,
   parameter int unsigned TSCALE  = 1,
   parameter int unsigned FRAC_W  = 8,
   parameter int unsigned OUT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic                        trigger,
   input  logic                        gate,
   input  logic                        loop,
   input  logic [$clog2(STAGES)-1:0]   sust_stage,
   input  logic [STAGES*LEVEL_W-1:0]   levels,
   input  logic [STAGES*TIME_W-1:0]    times,
   output logic [OUT_W-1:0]            env_out,
   output logic [$clog2(STAGES)-1:0]   stage,
   output logic                        busy,
   output logic                        eoc
);
   localparam int unsigned ACC_W = acc_w(LEVEL_W, FRAC_W);
   localparam int unsigned DEN_W = TIME_W + $clog2(TSCALE) + 1;
   localparam int unsigned SW    = $clog2(STAGES);
   localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

   env_state_t       state_q, end_state;
   logic [SW-1:0]    stage_q, end_stage;
   logic             end_eoc;
   logic [ACC_W-1:0] acc_q, target_q, step_q, tgt_w, diff_w, div_quo;
   logic [DEN_W-1:0] dur_q, cnt_q, dur_w;
   logic             dir_q, dir_w, setup_q, trig_q, trig_edge, eoc_q;
   logic             div_start, div_done;

   always_comb begin
      trig_edge = trigger & ~trig_q;
      tgt_w     = ACC_W'(levels[stage_q*LEVEL_W +: LEVEL_W]) << FRAC_W;
      dur_w     = DEN_W'(times[stage_q*TIME_W +: TIME_W]) * DEN_W'(TSCALE);
      dir_w     = (tgt_w >= acc_q) ? DIR_UP : DIR_DOWN;
      diff_w    = (dir_w == DIR_UP) ? tgt_w - acc_q : acc_q - tgt_w;
      div_start = (state_q == CALC) && setup_q && (dur_w != '0) && !trig_edge;
      // Stage-end decision, shared by zero-length CALC and the final RAMP tick
      end_state = CALC;
      end_stage = stage_q;
      end_eoc   = 1'b0;
      if ((stage_q == sust_stage) && gate) begin
         end_state = SUSTAIN;
      end else if (stage_q != LAST) begin
         end_stage = stage_q + SW'(1);
      end else if (loop && gate) begin
         end_stage = '0;
         end_eoc   = 1'b1;
      end else begin
         end_state = IDLE;
         end_eoc   = 1'b1;
      end
   end

   env_div #(
      .NUM_W (ACC_W),
      .DEN_W (DEN_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .abort (trig_edge),
      .num   (diff_w),
      .den   (dur_w),
      .done  (div_done),
      .quo   (div_quo)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         stage_q  <= '0;
         acc_q    <= '0;
         target_q <= '0;
         step_q   <= '0;
         dur_q    <= '0;
         cnt_q    <= '0;
         dir_q    <= DIR_UP;
         setup_q  <= 1'b0;
         trig_q   <= 1'b0;
         eoc_q    <= 1'b0;
      end else begin
         trig_q <= trigger;
         eoc_q  <= 1'b0;
         if (trig_edge) begin
            state_q <= CALC;
            stage_q <= '0;
            setup_q <= 1'b1;
         end else begin
            case (state_q)
               CALC: begin
                  if (setup_q) begin
                     target_q <= tgt_w;
                     dur_q    <= dur_w;
                     dir_q    <= dir_w;
                     setup_q  <= 1'b0;
                     if (dur_w == '0) begin
                        acc_q   <= tgt_w;
                        state_q <= end_state;
                        stage_q <= end_stage;
                        eoc_q   <= end_eoc;
                        setup_q <= 1'b1;
                     end
                  end else if (div_done) begin
                     step_q  <= div_quo;
                     cnt_q   <= dur_q;
                     state_q <= RAMP;
                  end
               end
               RAMP: begin
                  if (ena) begin
                     if (cnt_q == DEN_W'(1)) begin
                        acc_q   <= target_q;
                        state_q <= end_state;
                        stage_q <= end_stage;
                        eoc_q   <= end_eoc;
                        setup_q <= 1'b1;
                     end else begin
                        acc_q <= (dir_q == DIR_UP) ? acc_q + step_q : acc_q - step_q;
                        cnt_q <= cnt_q - DEN_W'(1);
                     end
                  end
               end
               SUSTAIN: begin
                  if (!gate) begin
                     if (stage_q == LAST) begin
                        state_q <= IDLE;
                        eoc_q   <= 1'b1;
                     end else begin
                        state_q <= CALC;
                        stage_q <= stage_q + SW'(1);
                        setup_q <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign env_out = acc_q[ACC_W-1 -: OUT_W];
   assign stage   = stage_q;
   assign busy    = (state_q != IDLE);
   assign eoc     = eoc_q;

endmodule

// File: tb/tb_env_ramp.sv
// Scoreboard bench for env_ramp: expected ramp values are queued from a
// small model and popped as each ena tick is consumed.
module tb_env_ramp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena, trigger, gate, loop;
   logic [1:0]  sust_stage;
   logic [31:0] levels;
   logic [31:0] times;
   logic [15:0] env_out;
   logic [1:0]  stage;
   logic        busy, eoc;

   int total = 0;
   int bad   = 0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   env_ramp #(
      .STAGES  (4),
      .LEVEL_W (8),
      .TIME_W  (8),
      .TSCALE  (1),
      .FRAC_W  (8),
      .OUT_W   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .trigger    (trigger),
      .gate       (gate),
      .loop       (loop),
      .sust_stage (sust_stage),
      .levels     (levels),
      .times      (times),
      .env_out    (env_out),
      .stage      (stage),
      .busy       (busy),
      .eoc        (eoc)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_stage(input int k, input int lvl, input int t);
      levels[k*8 +: 8] = 8'(lvl);
      times[k*8 +: 8]  = 8'(t);
   endtask

   // Linear ramp model: truncated step, last tick lands exactly on target.
   task automatic push_ramp(input int a, input int t, input int d, input int n);
      int step;
      step = (t >= a) ? (t - a) / d : (a - t) / d;
      for (int k = 1; k <= n; k++)
         sb.push_back(16'((k == d) ? t : ((t >= a) ? a + k * step : a - k * step)));
   endtask

   task automatic pulse_ena();
      ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
   endtask

   task automatic gap();
      repeat (31) @(negedge clk);
   endtask

   task automatic test_reset();
      ena = 1'b0; trigger = 1'b0; gate = 1'b1; loop = 1'b0; sust_stage = 2'd1;
      set_stage(0, 255, 4); set_stage(1, 128, 4); set_stage(2, 64, 4); set_stage(3, 0, 4);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (env_out !== 16'h0) begin bad++; $display("FAIL reset_env: got %h want 0000", env_out); end
      total++; if (stage !== 2'd0) begin bad++; $display("FAIL reset_stage: got %0d want 0", stage); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (eoc !== 1'b0) begin bad++; $display("FAIL reset_eoc: got %b want 0", eoc); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ramp_up(input string tag);
      logic [15:0] expv;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise: got %b want 1", tag, busy); end
      total++; if (stage !== 2'd0) begin bad++; $display("FAIL %s_stage0: got %0d want 0", tag, stage); end
      repeat (20) @(negedge clk);
      total++; if (env_out !== 16'h0) begin bad++; $display("FAIL %s_pre_tick: got %h want 0000", tag, env_out); end
      push_ramp(0, 'hFF00, 4, 4);
      for (int k = 0; k < 4; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL %s_tick%0d: got %h want %h", tag, k, env_out, expv); end
         gap();
      end
      total++; if (stage !== 2'd1) begin bad++; $display("FAIL %s_stage1: got %0d want 1", tag, stage); end
   endtask

   task automatic test_sustain();
      logic [15:0] expv;
      push_ramp('hFF00, 'h8000, 4, 4);
      for (int k = 0; k < 4; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL s1_down_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      for (int k = 0; k < 100; k++) begin
         pulse_ena();
         total++; if (env_out !== 16'h8000) begin bad++; $display("FAIL sustain_hold%0d: got %h want 8000", k, env_out); end
         gap();
      end
      total++; if (stage !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL sustain_state: got stage=%0d busy=%b want 1/1", stage, busy); end
      gate = 1'b0;
      push_ramp('h8000, 'h4000, 4, 4);
      repeat (18) @(negedge clk);
      pulse_ena();
      total++; if (env_out !== 16'h8000) begin bad++; $display("FAIL release_calc_ignore: got %h want 8000", env_out); end
      pulse_ena();
      expv = sb.pop_front();
      total++; if (env_out !== expv) begin bad++; $display("FAIL release_first: got %h want %h", env_out, expv); end
      gap();
      for (int k = 1; k < 4; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL s2_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      total++; if (stage !== 2'd3) begin bad++; $display("FAIL s2_end_stage: got %0d want 3", stage); end
   endtask

   task automatic test_retrigger();
      logic [15:0] expv;
      push_ramp('h4000, 0, 4, 2);
      for (int k = 0; k < 2; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL s3_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      gate = 1'b0;
      set_stage(2, 64, 0);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      total++; if (stage !== 2'd0) begin bad++; $display("FAIL retrig_stage: got %0d want 0", stage); end
      total++; if (env_out !== 16'h2000) begin bad++; $display("FAIL retrig_no_click: got %h want 2000", env_out); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL retrig_busy: got %b want 1", busy); end
      repeat (4) @(negedge clk);
      set_stage(0, 255, 8);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (14) @(negedge clk);
      pulse_ena();
      total++; if (env_out !== 16'h2000) begin bad++; $display("FAIL abort_calc_hold: got %h want 2000", env_out); end
      gap();
      push_ramp('h2000, 'hFF00, 8, 8);
      for (int k = 0; k < 8; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL retrig_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      total++; if (stage !== 2'd1) begin bad++; $display("FAIL retrig_end_stage: got %0d want 1", stage); end
   endtask

   task automatic test_zero_time();
      logic [15:0] expv;
      push_ramp('hFF00, 'h8000, 4, 4);
      for (int k = 0; k < 4; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL z_s1_tick%0d: got %h want %h", k, env_out, expv); end
         if (k < 3) gap();
      end
      total++; if (stage !== 2'd2) begin bad++; $display("FAIL zero_calc_stage: got %0d want 2", stage); end
      @(negedge clk);
      total++; if (env_out !== 16'h4000) begin bad++; $display("FAIL zero_time_load: got %h want 4000", env_out); end
      total++; if (stage !== 2'd3) begin bad++; $display("FAIL zero_time_next: got %0d want 3", stage); end
      gap();
   endtask

   task automatic test_eoc();
      logic [15:0] expv;
      push_ramp('h4000, 0, 4, 4);
      for (int k = 0; k < 4; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL last_tick%0d: got %h want %h", k, env_out, expv); end
         if (k < 3) gap();
      end
      total++; if (eoc !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL eoc_idle: got eoc=%b busy=%b want 1/0", eoc, busy); end
      @(negedge clk);
      total++; if (eoc !== 1'b0) begin bad++; $display("FAIL eoc_width: got %b want 0", eoc); end
      set_stage(0, 255, 4); set_stage(1, 128, 1); set_stage(2, 64, 0); set_stage(3, 0, 2);
      gate = 1'b0; loop = 1'b0;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (20) @(negedge clk);
      push_ramp(0, 'hFF00, 4, 4);
      push_ramp('hFF00, 'h8000, 1, 1);
      for (int k = 0; k < 5; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL loop_pre_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      total++; if (env_out !== 16'h4000 || stage !== 2'd3) begin bad++; $display("FAIL loop_s2: got %h/%0d want 4000/3", env_out, stage); end
      gate = 1'b1; loop = 1'b1;
      push_ramp('h4000, 0, 2, 2);
      for (int k = 0; k < 2; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL loop_s3_tick%0d: got %h want %h", k, env_out, expv); end
         if (k == 0) gap();
      end
      total++; if (eoc !== 1'b1 || stage !== 2'd0 || busy !== 1'b1) begin
         bad++; $display("FAIL loop_wrap: got eoc=%b stage=%0d busy=%b want 1/0/1", eoc, stage, busy);
      end
      gap();
   endtask

   task automatic test_async_reset();
      logic [15:0] expv;
      push_ramp(0, 'hFF00, 4, 2);
      for (int k = 0; k < 2; k++) begin
         pulse_ena();
         expv = sb.pop_front();
         total++; if (env_out !== expv) begin bad++; $display("FAIL loop_s0_tick%0d: got %h want %h", k, env_out, expv); end
         gap();
      end
      #3 rst = 1'b0;
      #1;
      total++; if (env_out !== 16'h0) begin bad++; $display("FAIL async_env: got %h want 0000", env_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
      total++; if (stage !== 2'd0 || eoc !== 1'b0) begin bad++; $display("FAIL async_stage_eoc: got %0d/%b want 0/0", stage, eoc); end
      @(negedge clk);
      rst = 1'b1; loop = 1'b0;
      @(negedge clk);
      test_ramp_up("s6");
   endtask

   initial begin
      test_reset();
      test_ramp_up("s1");
      test_sustain();
      test_retrigger();
      test_zero_time();
      test_eoc();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/env_ramp.md
# env_ramp

Multi-stage envelope generator that ramps linearly between programmed breakpoint levels instead of stepping. It is the parametrised successor to the stepped envelope: breakpoint count, level/time/fraction widths and output width are all parameters. It adds gate-held sustain, looping, and retrigger from the current level. It sits between the control/sequencer logic and the VCA/filter modulation inputs and advances once per sample tick (`ena`).

## Interface

- `STAGES`, 4: number of ramp stages (≥2).
- `LEVEL_W`, 8: breakpoint level width, unsigned.
- `TIME_W`, 8: stage duration width, in units of `TSCALE` ticks.
- `TSCALE`, 1: tick multiplier for every stage duration.
- `FRAC_W`, 8: fractional bits of the accumulator. `ACC_W = LEVEL_W + FRAC_W`.
- `OUT_W`, 16: output width. Must satisfy `OUT_W ≤ ACC_W`.

Ports:

- `clk` in 1: clock. One clock for the whole block.
- `rst` in 1: reset, asynchronous, active-low.
- `ena` in 1: sample tick. One clk wide.
- `trigger` in 1: start; its rising edge is detected on `clk`.
- `gate` in 1: sustain hold while high.
- `loop` in 1: restart at stage 0 after the last stage while `gate` is high.
- `sust_stage` in `$clog2(STAGES)`: sustain holds at the end of this stage.
- `levels` in `STAGES*LEVEL_W`: target level of stage k is `levels[k*LEVEL_W +: LEVEL_W]`.
- `times` in `STAGES*TIME_W`: duration of stage k is `times[k*TIME_W +: TIME_W]`.
- `env_out` out `OUT_W`: `acc[ACC_W-1 -: OUT_W]`.
- `stage` out `$clog2(STAGES)`: current stage index.
- `busy` out 1: high in every state except `IDLE`.
- `eoc` out 1: one-clk pulse when the last stage completes.

## Operation

- Accumulator `acc` is unsigned `ACC_W` bits: integer level in the top `LEVEL_W` bits, fraction below.
- **States:**
  - `IDLE`: `acc` holds its value.
  - `CALC`: latch `target = levels[stage]<<FRAC_W`, `D = times[stage]*TSCALE`, and start the divider.
    - If `D == 0`: `acc ← target`, then go to stage-end handling.
    - Otherwise: `step = |target − acc| / D`, truncated toward zero. `dir` records the sign. Go to `RAMP` when the divider is done.
  - `RAMP`: on each `ena`, `acc ± step` and `cnt−1`. On the tick where `cnt` reaches 0, `acc ← target` exactly, which removes the rounding residue. Truncated `step` guarantees no overshoot or wrap.
  - **Stage end:**
    - `stage == sust_stage` and `gate` high → `SUSTAIN`.
    - Otherwise, if stage is not last → `stage+1`, `CALC`.
    - Last stage with `loop && gate` → `stage ← 0`, `CALC`, pulse `eoc`.
    - Last stage otherwise → `IDLE`, pulse `eoc`.
  - `SUSTAIN`: holds `acc`. When `gate` goes low → `stage+1`, `CALC`; if `sust_stage` is the last stage, go to `IDLE` with `eoc`.
- **Retrigger:** a `trigger` rising edge in any state → `stage ← 0`, `CALC`, and any divide in progress is aborted. `acc` is not reset, so the ramp starts from the current level with no click.
- `levels`/`times` are sampled only at `CALC` entry. Changes during a stage take effect at the next stage.
- `ena` ticks arriving during `CALC` are ignored. The divider runs on `clk` independently of `ena`.
- **Simultaneous events:** a trigger edge beats stage-end, `gate` changes and `loop` in the same cycle.

## Timing

- **Reset values:** `acc`=0, `env_out`=0, `stage`=0, `busy`=0, `eoc`=0, state `IDLE`, trigger edge register 0.
- **Reset mid-operation:** `env_out` goes to 0 asynchronously, whatever the state.
- **Trigger edge:** registered. `CALC` is entered the clk after `trigger` is first seen high, and `busy` rises then.
- **`CALC` latency:** `ACC_W+2` clk (1 setup, `ACC_W` divide, 1 load). With `D==0`, `CALC` lasts 1 clk.
- **Ramp update:** `env_out` changes 1 clk after each `ena` consumed in `RAMP`.
- **Tick spacing:** `ena` ticks must be at least `ACC_W+3` clk apart for stage lengths to be exact.
- **`eoc`:** high for exactly 1 clk, in the cycle the state leaves the last stage.

## Structure

- Package `env_pkg` contains:
  - state enum `env_state_t` {IDLE, CALC, RAMP, SUSTAIN};
  - function `acc_w(LEVEL_W, FRAC_W)`;
  - a direction localparam.
- Sub-module `env_div`: sequential restoring unsigned divider.
  - Parameters: `ACC_W` for the numerator, `TIME_W+$clog2(TSCALE)+1` for the denominator.
  - Ports: `start`/`abort`/`done` handshake, quotient output.
  - Processes one bit per clk.

## Test plan

All scenarios use defaults, `ACC_W`=16 and `ena` every 32 clk.

1. From reset, `levels[0]`=255, `times[0]`=4, trigger → `env_out` 0x3FC0, 0x7F80, 0xBF40, then 0xFF00 on the 4th tick; `stage` becomes 1.
2. `sust_stage`=1, `levels[1]`=128, `gate` high → `env_out` holds 0x8000 for 100 ticks. `gate` low → stage 2 ramp begins within `ACC_W+2` clk.
3. `times[2]`=0, `levels[2]`=64 → `env_out`=0x4000 one clk after stage-2 `CALC`, with no ticks consumed.
4. Retrigger mid-stage-3 at `env_out`=0x2000 → `stage`=0. Ramp toward 0xFF00 starts from 0x2000 with no discontinuity. Divider abort is verified.
5. Last stage ends with `gate` low → one-clk `eoc`, `busy`=0. Same with `loop`=1 and `gate` high → `eoc` pulse and `stage`=0.
6. `rst` low mid-ramp, asynchronous to `clk` → `env_out`=0, `busy`=0 immediately. Release, then trigger → scenario 1 reproduces.
